// File: rtl/regfile_wb_arb_pkg.sv
// Shared helpers for the write-back arbiter slice.
// Width helpers are kept here so the arbiter core and the top derive widths identically.
package regfile_wb_arb_pkg;

    // Index width for an n-way select; a single-entry select still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Address width for an n-entry register file.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arb_if.sv
// Bundle of the write-back producer handshakes and the register-file write port.
interface regfile_wb_arb_if
    import regfile_wb_arb_pkg::*;
#(
    parameter int NUM_WB    = 3,
    parameter int NUM_REG   = 32,
    parameter int REG_WIDTH = 32
);
    localparam int ADDR_W = addr_width(NUM_REG);

    logic                                stall_i;
    logic [NUM_WB-1:0]                   wb_valid_i;
    logic [NUM_WB-1:0][ADDR_W-1:0]       wb_addr_i;
    logic [NUM_WB-1:0][REG_WIDTH-1:0]    wb_data_i;
    logic [NUM_WB-1:0]                   wb_ready_o;
    logic [ADDR_W-1:0]                   rd_addr_o;
    logic [REG_WIDTH-1:0]                rd_data_o;
    logic                                rd_en_o;
    logic [NUM_REG-1:0]                  busy_o;

    modport slave (
        input  stall_i, wb_valid_i, wb_addr_i, wb_data_i,
        output wb_ready_o, rd_addr_o, rd_data_o, rd_en_o, busy_o
    );

    modport master (
        output stall_i, wb_valid_i, wb_addr_i, wb_data_i,
        input  wb_ready_o, rd_addr_o, rd_data_o, rd_en_o, busy_o
    );
endinterface

// File: rtl/regfile_wb_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer.
// The pointer moves just past the winner, so every requester is served within NUM_REQ grants.
module regfile_wb_arb_rr_arbiter
    import regfile_wb_arb_pkg::*;
#(
    parameter int  NUM_REQ = 3,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);
    localparam logic [IDX_W:0]   NUM_REQ_C = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W:0]   sum_s;
    logic [IDX_W:0]   wrap_s;
    logic [IDX_W-1:0] cand_s;
    logic             hit_s;
    logic             found_s;

    // Wrapped priority search starting at the pointer, plus pointer advance on a grant.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found_s   = 1'b0;
        sum_s     = '0;
        wrap_s    = '0;
        cand_s    = '0;
        hit_s     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s          = {1'b0, ptr_q} + (IDX_W+1)'(i);
            wrap_s         = (sum_s >= NUM_REQ_C) ? (sum_s - NUM_REQ_C) : sum_s;
            cand_s         = wrap_s[IDX_W-1:0];
            hit_s          = en_i & ~found_s & req_i[cand_s];
            gnt_o[cand_s]  = gnt_o[cand_s] | hit_s;
            gnt_idx_o      = hit_s ? cand_s : gnt_idx_o;
            found_s        = found_s | hit_s;
        end
        if (!found_s) begin
            ptr_d = ptr_q;
        end else if (gnt_idx_o == LAST_IDX) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_idx_o + IDX_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/regfile_wb_arb.sv
// Write-back arbiter: round-robin selection among producers into one registered
// register-file write port, with optional discard of writes to register 0.
module regfile_wb_arb
    import regfile_wb_arb_pkg::*;
#(
    parameter int NUM_WB    = 3,
    parameter bit ZERO_REG  = 1'b1,
    parameter int NUM_REG   = 32,
    parameter int REG_WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             arst_i,
    regfile_wb_arb_if.slave  bus
);
    localparam int ADDR_W = addr_width(NUM_REG);
    localparam int IDX_W  = idx_width(NUM_WB);

    if (NUM_WB < 1 || NUM_REG < 2) begin : g_bad_param
        $error("regfile_wb_arb: NUM_WB must be >= 1 and NUM_REG >= 2");
    end

    logic [NUM_WB-1:0]    gnt_s;
    logic [IDX_W-1:0]     gnt_idx_s;
    logic                 grant_en_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [REG_WIDTH-1:0] sel_data_s;
    logic                 emit_s;

    logic                 rd_en_d,   rd_en_q;
    logic [ADDR_W-1:0]    rd_addr_d, rd_addr_q;
    logic [REG_WIDTH-1:0] rd_data_d, rd_data_q;
    logic [NUM_REG-1:0]   busy_d,    busy_q;

    // Reset also blocks grants so no handshake completes while the output stage is held clear.
    assign grant_en_s = ~bus.stall_i & ~arst_i;

    regfile_wb_arb_rr_arbiter #(
        .NUM_REQ (NUM_WB)
    ) u_arb (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .en_i      (grant_en_s),
        .req_i     (bus.wb_valid_i),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s)
    );

    assign bus.wb_ready_o = gnt_s;

    // Select the granted producer's address and data.
    always_comb begin
        sel_addr_s = bus.wb_addr_i[gnt_idx_s];
        sel_data_s = bus.wb_data_i[gnt_idx_s];
    end

    // Next output-stage contents; address and data hold when nothing is emitted.
    always_comb begin
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        busy_d    = '0;
        emit_s    = (|gnt_s) & ~(ZERO_REG & (sel_addr_s == '0));
        if (emit_s) begin
            rd_en_d   = 1'b1;
            rd_addr_d = sel_addr_s;
            rd_data_d = sel_data_s;
            busy_d    = {{(NUM_REG-1){1'b0}}, 1'b1} << sel_addr_s;
        end else begin
            rd_en_d   = 1'b0;
        end
    end

    // Output stage; busy is decoded ahead of the flop so it carries no input path.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.rd_en_o   = rd_en_q;
    assign bus.rd_addr_o = rd_addr_q;
    assign bus.rd_data_o = rd_data_q;
    assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: directed scenarios plus random traffic, with a
// behavioural model checked every cycle on a ZERO_REG=1 and a ZERO_REG=0 instance.
module tb_regfile_wb_arb;
    logic                 clk = 1'b0;
    logic                 arst;
    logic                 stall;
    logic [2:0]           valid;
    logic [2:0][4:0]      addr;
    logic [2:0][31:0]     data;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arb_if #(.NUM_WB(3), .NUM_REG(32), .REG_WIDTH(32)) bus_z ();
    regfile_wb_arb_if #(.NUM_WB(3), .NUM_REG(32), .REG_WIDTH(32)) bus_nz ();

    assign bus_z.stall_i     = stall;
    assign bus_z.wb_valid_i  = valid;
    assign bus_z.wb_addr_i   = addr;
    assign bus_z.wb_data_i   = data;
    assign bus_nz.stall_i    = stall;
    assign bus_nz.wb_valid_i = valid;
    assign bus_nz.wb_addr_i  = addr;
    assign bus_nz.wb_data_i  = data;

    regfile_wb_arb #(.NUM_WB(3), .ZERO_REG(1'b1), .NUM_REG(32), .REG_WIDTH(32)) dut_z (
        .clk_i (clk), .arst_i (arst), .bus (bus_z)
    );
    regfile_wb_arb #(.NUM_WB(3), .ZERO_REG(1'b0), .NUM_REG(32), .REG_WIDTH(32)) dut_nz (
        .clk_i (clk), .arst_i (arst), .bus (bus_nz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: index 0 mirrors the ZERO_REG=1 instance, index 1 the ZERO_REG=0 one.
    int          m_ptr;
    logic        m_en   [2];
    logic [4:0]  m_addr [2];
    logic [31:0] m_data [2];
    int          exp_j;
    int          s;
    logic [2:0]  exp_rdy;

    task m_reset();
        m_ptr = 0;
        for (int i = 0; i < 2; i++) begin
            m_en[i] = 1'b0; m_addr[i] = 5'd0; m_data[i] = 32'd0;
        end
    endtask

    task automatic chk_port(input string tag, input logic en, input logic [4:0] a,
                            input logic [31:0] d, input logic [31:0] busy, input int k);
        chk({tag, "_rd_en"}, 64'(en), 64'(m_en[k]));
        chk({tag, "_rd_addr"}, 64'(a), 64'(m_addr[k]));
        chk({tag, "_rd_data"}, 64'(d), 64'(m_data[k]));
        chk({tag, "_busy"}, 64'(busy), m_en[k] ? 64'(32'h1 << m_addr[k]) : 64'd0);
    endtask

    // Reference model and per-cycle compare.
    initial begin : model_proc
        m_reset();
        forever begin
            @(negedge clk);
            exp_j = -1;
            if (arst) begin
                m_reset();
                exp_rdy = 3'b000;
            end else begin
                if (!stall) begin
                    for (int k = 0; k < 3; k++) begin
                        s = (m_ptr + k) % 3;
                        if (exp_j < 0 && valid[s]) exp_j = s;
                    end
                end
                exp_rdy = (exp_j >= 0) ? 3'(1 << exp_j) : 3'b000;
            end
            chk("m_ready_z", 64'(bus_z.wb_ready_o), 64'(exp_rdy));
            chk("m_ready_nz", 64'(bus_nz.wb_ready_o), 64'(exp_rdy));
            chk_port("m_z", bus_z.rd_en_o, bus_z.rd_addr_o, bus_z.rd_data_o, bus_z.busy_o, 0);
            chk_port("m_nz", bus_nz.rd_en_o, bus_nz.rd_addr_o, bus_nz.rd_data_o, bus_nz.busy_o, 1);
            @(posedge clk);
            if (arst) begin
                m_reset();
            end else if (exp_j < 0) begin
                m_en[0] = 1'b0;
                m_en[1] = 1'b0;
            end else begin
                m_ptr = (exp_j + 1) % 3;
                if (addr[exp_j] != 5'd0) begin
                    m_en[0] = 1'b1; m_addr[0] = addr[exp_j]; m_data[0] = data[exp_j];
                end else begin
                    m_en[0] = 1'b0;
                end
                m_en[1] = 1'b1; m_addr[1] = addr[exp_j]; m_data[1] = data[exp_j];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] xfer;

    initial begin : stim
        arst = 1'b1; stall = 1'b0; valid = 3'b000; addr = '0; data = '0;
        @(negedge clk);
        chk("reset_rd_en", 64'(bus_z.rd_en_o), 64'd0);
        chk("reset_busy", 64'(bus_z.busy_o), 64'd0);
        repeat (2) @(posedge clk);
        #1; arst = 1'b0;

        // Round-robin: all sources valid, addresses 1,2,3.
        valid = 3'b111;
        addr[0] = 5'd1; addr[1] = 5'd2; addr[2] = 5'd3;
        data[0] = 32'h11; data[1] = 32'h22; data[2] = 32'h33;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("rr_ready", 64'(bus_z.wb_ready_o), 64'(3'b001 << (n % 3)));
            if (n > 0) begin
                chk("rr_en", 64'(bus_z.rd_en_o), 64'd1);
                chk("rr_addr", 64'(bus_z.rd_addr_o), 64'((n - 1) % 3 + 1));
            end
            cyc();
        end
        valid = 3'b000;
        @(negedge clk);
        chk("rr_last_addr", 64'(bus_z.rd_addr_o), 64'd3);
        cyc();

        // Stall: one grant to source 0, then three stalled cycles.
        valid = 3'b111;
        @(negedge clk);
        chk("pre_stall_ready", 64'(bus_z.wb_ready_o), 64'd1);
        cyc();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ready", 64'(bus_z.wb_ready_o), 64'd0);
            if (k > 0) chk("stall_rd_en", 64'(bus_z.rd_en_o), 64'd0);
            cyc();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("stall_resume_ready", 64'(bus_z.wb_ready_o), 64'b010);
        chk("stall_resume_en", 64'(bus_z.rd_en_o), 64'd0);
        cyc();
        valid = 3'b000;
        @(negedge clk);
        chk("stall_resume_addr", 64'(bus_z.rd_addr_o), 64'd2);
        cyc();

        // Single source 1 writes r5.
        valid = 3'b010; addr[1] = 5'd5; data[1] = 32'hDEADBEEF;
        @(negedge clk);
        chk("single_ready", 64'(bus_z.wb_ready_o), 64'b010);
        cyc();
        valid = 3'b000;
        @(negedge clk);
        chk("single_en", 64'(bus_z.rd_en_o), 64'd1);
        chk("single_addr", 64'(bus_z.rd_addr_o), 64'd5);
        chk("single_data", 64'(bus_z.rd_data_o), 64'hDEADBEEF);
        chk("single_busy", 64'(bus_z.busy_o), 64'h20);
        cyc();
        @(negedge clk);
        chk("single_en_drop", 64'(bus_z.rd_en_o), 64'd0);
        cyc();

        // Zero register from source 2, then same-register back-to-back from 0 and 1.
        valid = 3'b100; addr[2] = 5'd0; data[2] = 32'h1234;
        @(negedge clk);
        chk("zero_ready", 64'(bus_z.wb_ready_o), 64'b100);
        cyc();
        valid = 3'b011; addr[0] = 5'd7; data[0] = 32'hA; addr[1] = 5'd7; data[1] = 32'hB;
        @(negedge clk);
        chk("zero_ptr_wrap_ready", 64'(bus_z.wb_ready_o), 64'b001);
        chk("zero_z_en", 64'(bus_z.rd_en_o), 64'd0);
        chk("zero_z_busy", 64'(bus_z.busy_o), 64'd0);
        chk("zero_nz_en", 64'(bus_nz.rd_en_o), 64'd1);
        chk("zero_nz_addr", 64'(bus_nz.rd_addr_o), 64'd0);
        chk("zero_nz_data", 64'(bus_nz.rd_data_o), 64'h1234);
        cyc();
        valid = 3'b010;
        @(negedge clk);
        chk("same_ready2", 64'(bus_z.wb_ready_o), 64'b010);
        chk("same_data_a", 64'(bus_z.rd_data_o), 64'hA);
        chk("same_busy_a", 64'(bus_z.busy_o), 64'h80);
        cyc();
        valid = 3'b000;
        @(negedge clk);
        chk("same_data_b", 64'(bus_z.rd_data_o), 64'hB);
        chk("same_busy_b", 64'(bus_z.busy_o), 64'h80);
        cyc();

        // Asynchronous reset while a write sits in the output stage.
        valid = 3'b001; addr[0] = 5'd9; data[0] = 32'h99;
        @(negedge clk);
        chk("arst_pre_ready", 64'(bus_z.wb_ready_o), 64'b001);
        cyc();
        valid = 3'b111;
        chk("arst_pre_en", 64'(bus_z.rd_en_o), 64'd1);
        #1; arst = 1'b1;
        #1;
        chk("arst_en", 64'(bus_z.rd_en_o), 64'd0);
        chk("arst_addr", 64'(bus_z.rd_addr_o), 64'd0);
        chk("arst_data", 64'(bus_z.rd_data_o), 64'd0);
        chk("arst_busy", 64'(bus_z.busy_o), 64'd0);
        chk("arst_ready", 64'(bus_z.wb_ready_o), 64'd0);
        cyc();
        arst = 1'b0;
        @(negedge clk);
        chk("arst_first_grant", 64'(bus_z.wb_ready_o), 64'b001);
        xfer = bus_z.wb_ready_o & valid;

        // Random traffic; sources keep requests stable until accepted.
        for (int c = 0; c < 3000; c++) begin
            cyc();
            for (int i = 0; i < 3; i++) begin
                if (!valid[i] || xfer[i]) begin
                    valid[i] = ($urandom_range(3) != 0);
                    addr[i]  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                    data[i]  = $urandom;
                end
            end
            stall = ($urandom_range(5) == 0);
            @(negedge clk);
            xfer = bus_z.wb_ready_o & valid;
        end
        cyc();
        valid = 3'b000; stall = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
